// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer granting one shared memory to the CPU or a second requester.
// Optional ACCESS timeout abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    if (TIMEOUT < 1) begin : gen_bad_timeout
        $error("TIMEOUT must be >= 1");
    end

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    // Requester encoding: 0 = CPU, 1 = second requester.
    logic          winner_q, winner_d;
    logic          last_q, last_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
`endif

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        winner_d = winner_q;
        last_d   = last_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        to_d     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (c_req || d_req) begin
                    // On contention the requester not granted last time wins.
                    winner_d = (c_req && d_req) ? ~last_q : d_req;
                    we_d     = winner_d ? d_we    : c_we;
                    addr_d   = winner_d ? d_addr  : c_addr;
                    wdata_d  = winner_d ? d_wdata : c_wdata;
                    state_d  = StAccess;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            StAccess: begin
                if (m_ack) begin
                    rdata_d = m_rdata;
                    last_d  = winner_q;
                    state_d = StResp;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '1;
                    last_d  = winner_q;
                    to_d    = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            winner_q <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            winner_q <= winner_d;
            last_q   <= last_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign err = to_q;
`else
    assign err = 1'b0;
`endif

    // Outputs decode straight from state so reset drops m_req asynchronously.
    assign m_req   = (state_q == StAccess);
    assign m_we    = m_req & we_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign busy    = (state_q != StIdle);
    assign c_ack   = (state_q == StResp) & ~winner_q;
    assign d_ack   = (state_q == StResp) & winner_q;
    assign c_rdata = rdata_q;
    assign d_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; timeout cases run when MEM_ARB_TIMEOUT_EN is set.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0, m_ack = 0;
    logic [31:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
    logic [31:0] c_rdata, d_rdata, m_addr, m_wdata;
    logic        c_ack, d_ack, m_req, m_we, busy, err;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from IDLE; memory acks in ACCESS cycle 'lat'.
    task automatic run_single(input bit is_d, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] mdata, input int lat);
        if (is_d) begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            c_req = 1; c_we = we; c_addr = addr; c_wdata = wdata;
        end
        step();
        for (int i = 1; i <= lat; i++) begin
            check_eq("acc_mreq", 32'(m_req), 1);
            check_eq("acc_mwe", 32'(m_we), 32'(we));
            check_eq("acc_addr", m_addr, addr);
            check_eq("acc_wdata", m_wdata, wdata);
            check_eq("acc_busy", 32'(busy), 1);
            check_eq("acc_acks", 32'({c_ack, d_ack}), 0);
            // Scramble requester inputs: only the latched copies may reach memory.
            c_addr = ~addr; d_addr = ~addr; c_wdata = ~wdata; d_wdata = ~wdata;
            c_we = ~we; d_we = ~we;
            m_ack = (i == lat);
            m_rdata = mdata;
            step();
        end
        check_eq("resp_mreq", 32'(m_req), 0);
        check_eq("resp_mwe", 32'(m_we), 0);
        check_eq("resp_c_ack", 32'(c_ack), 32'(!is_d));
        check_eq("resp_d_ack", 32'(d_ack), 32'(is_d));
        check_eq("resp_rdata", is_d ? d_rdata : c_rdata, mdata);
        check_eq("resp_err", 32'(err), 0);
        check_eq("resp_busy", 32'(busy), 1);
        c_req = 0; d_req = 0; m_ack = 0; m_rdata = 32'hDEAD_BEEF;
        step();
        check_eq("idle_acks", 32'({c_ack, d_ack}), 0);
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_mreq", 32'(m_req), 0);
    endtask

    initial begin
        step();
        step();
        check_eq("rst_mreq", 32'(m_req), 0);
        check_eq("rst_mwe", 32'(m_we), 0);
        check_eq("rst_maddr", m_addr, 0);
        check_eq("rst_mwdata", m_wdata, 0);
        check_eq("rst_acks", 32'({c_ack, d_ack}), 0);
        check_eq("rst_rdata", c_rdata, 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_err", 32'(err), 0);
        reset = 0;

        // CPU read with immediate memory ack.
        run_single(1'b0, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 1);
        // Second requester write, memory acks in the third ACCESS cycle.
        run_single(1'b1, 1'b1, 32'h80, 32'hCAFE_F00D, 32'h0BAD_0BAD, 3);

        // Both requesters held: last grant was D, so order is C, D, C, D.
        for (int k = 0; k < 4; k++) begin
            bit exp_d;
            exp_d = (k % 2) == 1;
            c_req = 1; d_req = 1; c_we = 0; d_we = 0;
            c_addr = 32'h10; d_addr = 32'h20;
            step();
            check_eq("rr_mreq", 32'(m_req), 1);
            check_eq("rr_addr", m_addr, exp_d ? 32'h20 : 32'h10);
            m_ack = 1; m_rdata = 32'hA000_0000 + k;
            step();
            check_eq("rr_c_ack", 32'(c_ack), 32'(!exp_d));
            check_eq("rr_d_ack", 32'(d_ack), 32'(exp_d));
            check_eq("rr_rdata", c_rdata, 32'hA000_0000 + k);
            m_ack = 0;
            if (k == 3) begin
                c_req = 0; d_req = 0;
            end
            step();
            check_eq("rr_idle_busy", 32'(busy), 0);
            check_eq("rr_idle_acks", 32'({c_ack, d_ack}), 0);
        end

        // Leave last grant at C, then reset mid-ACCESS of a D request.
        run_single(1'b0, 1'b0, 32'h200, 32'h0, 32'h7777_0000, 1);
        d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h1;
        step();
        check_eq("pre_rst_mreq", 32'(m_req), 1);
        reset = 1;
        #1;
        check_eq("rst_async_mreq", 32'(m_req), 0);
        check_eq("rst_async_busy", 32'(busy), 0);
        check_eq("rst_async_maddr", m_addr, 0);
        d_req = 0;
        step();
        check_eq("rst_no_ack", 32'({c_ack, d_ack}), 0);
        reset = 0;
        c_req = 1; d_req = 1; c_we = 0; d_we = 0;
        c_addr = 32'h400; d_addr = 32'h500;
        step();
        check_eq("post_rst_grant", m_addr, 32'h400);
        m_ack = 1; m_rdata = 32'h0000_0042;
        step();
        check_eq("post_rst_c_ack", 32'(c_ack), 1);
        check_eq("post_rst_d_ack", 32'(d_ack), 0);
        m_ack = 0; c_req = 0; d_req = 0;
        step();

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never acks: four ACCESS cycles then aborted ack with err.
        c_req = 1; c_we = 0; c_addr = 32'h100;
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq("to_mreq", 32'(m_req), 1);
            check_eq("to_acks", 32'({c_ack, d_ack}), 0);
            step();
        end
        check_eq("to_resp_mreq", 32'(m_req), 0);
        check_eq("to_c_ack", 32'(c_ack), 1);
        check_eq("to_err", 32'(err), 1);
        check_eq("to_rdata", c_rdata, 32'hFFFF_FFFF);
        c_req = 0;
        step();
        check_eq("to_err_clear", 32'(err), 0);
        check_eq("to_ack_clear", 32'(c_ack), 0);
        // Ack on the last allowed cycle completes normally.
        run_single(1'b0, 1'b0, 32'h104, 32'h0, 32'h5555_AAAA, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
